// File: rtl/dmem_responder.sv
// dmem_responder: multi-cycle data-memory target for the core's load/store port.
// One request at a time: IDLE accepts, WAIT burns WAIT_CYCLES, RESP holds the result
// until the requester takes it. Byte-lane rules follow RISC-V LB/LH/LW/LBU/LHU/SB/SH/SW.
// Optional macro DMEM_MISALIGN_ERR_EN: misaligned half/word accesses become errors;
// without it, half/word accesses are forced aligned.
module dmem_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned WAIT_CYCLES = 1,
  parameter logic [31:0] ADDR_BASE   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);
  localparam int unsigned AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic        cap_write;
  logic [31:0] cap_addr;
  logic [2:0]  cap_f3;
  logic [31:0] cap_wdata;

  logic [31:0] mem [DEPTH_WORDS];

  logic [31:0] offset;
  logic [29:0] idx;
  logic [AW-1:0] widx;
  logic        addr_err, f3_err, mis_err, err, commit;
  logic [31:0] rword, load_val, wd;
  logic [7:0]  rbyte;
  logic [15:0] rhalf;
  logic [3:0]  be;

  // Decode the captured request: legality, lane selection and load formatting.
  always_comb begin
    offset   = cap_addr - ADDR_BASE;
    idx      = offset[31:2];
    widx     = idx[AW-1:0];
    addr_err = (cap_addr < ADDR_BASE) || ({2'b00, idx} >= DEPTH_WORDS);
    case (cap_f3)
      3'b000, 3'b001, 3'b010: f3_err = 1'b0;
      3'b100, 3'b101:         f3_err = cap_write;  // unsigned forms are load-only
      default:                f3_err = 1'b1;
    endcase
`ifdef DMEM_MISALIGN_ERR_EN
    case (cap_f3[1:0])
      2'b01:   mis_err = offset[0];
      2'b10:   mis_err = |offset[1:0];
      default: mis_err = 1'b0;
    endcase
`else
    mis_err = 1'b0;
`endif
    err    = addr_err | f3_err | mis_err;
    commit = (state == S_WAIT) && (cnt == 4'd0);

    // Half lane ignores offset[0] and word ignores offset[1:0]: forced alignment.
    rword = mem[widx];
    rbyte = 8'(rword >> {offset[1:0], 3'b000});
    rhalf = offset[1] ? rword[31:16] : rword[15:0];
    case (cap_f3)
      3'b000:  load_val = {{24{rbyte[7]}}, rbyte};
      3'b001:  load_val = {{16{rhalf[15]}}, rhalf};
      3'b100:  load_val = {24'd0, rbyte};
      3'b101:  load_val = {16'd0, rhalf};
      default: load_val = rword;
    endcase

    case (cap_f3[1:0])
      2'b00: begin
        be = 4'b0001 << offset[1:0];
        wd = {4{cap_wdata[7:0]}};
      end
      2'b01: begin
        be = offset[1] ? 4'b1100 : 4'b0011;
        wd = {2{cap_wdata[15:0]}};
      end
      default: begin
        be = 4'b1111;
        wd = cap_wdata;
      end
    endcase
  end

  // Store commit: only on the edge that raises rsp_valid; the array itself is never reset.
  always_ff @(posedge clk) begin
    if (commit && cap_write && !err) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[widx][8*i +: 8] <= wd[8*i +: 8];
      end
    end
  end

  // Control FSM with registered handshake and response outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      cnt       <= 4'd0;
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'd0;
      rsp_err   <= 1'b0;
      cap_write <= 1'b0;
      cap_addr  <= 32'd0;
      cap_f3    <= 3'd0;
      cap_wdata <= 32'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid && req_ready) begin
            cap_write <= req_write;
            cap_addr  <= req_addr;
            cap_f3    <= req_funct3;
            cap_wdata <= req_wdata;
            cnt       <= 4'(WAIT_CYCLES);
            req_ready <= 1'b0;
            state     <= S_WAIT;
          end else begin
            req_ready <= 1'b1;
          end
        end
        S_WAIT: begin
          if (cnt == 4'd0) begin
            rsp_valid <= 1'b1;
            rsp_err   <= err;
            rsp_rdata <= (err || cap_write) ? 32'd0 : load_val;
            state     <= S_RESP;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            rsp_rdata <= 32'd0;
            rsp_err   <= 1'b0;
            req_ready <= 1'b1;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed byte-lane/error/reset sequences plus randomized traffic,
// checked every cycle against a byte-array memory model and a cycle-count timing model.
module tb_dmem_responder;
  localparam int W     = 1;
  localparam int DEPTH = 1024;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0, req_write = 1'b0, rsp_ready = 1'b0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic [2:0]  req_funct3 = '0;
  logic        req_ready, rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;

  dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(W), .ADDR_BASE(32'h0)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_funct3(req_funct3), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Reference model: memory as bytes, timing as "response W+1 edges after accept".
  logic [7:0]  mb [0:63];
  logic        m_ready = 1'b0, m_valid = 1'b0, m_err = 1'b0;
  logic [31:0] m_rdata = '0;
  bit          busy = 0;
  int          cyc = 0, acc_cyc = 0;
  logic        p_w;
  logic [31:0] p_a, p_wd;
  logic [2:0]  p_f3;

  task automatic model_access();
    logic [31:0] off, val;
    int size, b;
    logic bad;
    off  = p_a - 32'h0;
    size = 1 << p_f3[1:0];
    bad  = (off >> 2) >= DEPTH;
    if (p_w) bad = bad | !(p_f3 inside {3'd0, 3'd1, 3'd2});
    else     bad = bad | !(p_f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
`ifdef DMEM_MISALIGN_ERR_EN
    if ((off % size) != 0) bad = 1'b1;
`endif
    m_err   = bad;
    m_rdata = 32'd0;
    if (bad) return;
    b = int'(off) & ~(size - 1);
    if (p_w) begin
      for (int k = 0; k < size; k++) mb[b+k] = p_wd[8*k +: 8];
    end else begin
      val = 32'd0;
      for (int k = 0; k < size; k++) val = val | (32'(mb[b+k]) << (8*k));
      if (!p_f3[2] && size < 4 && val[8*size-1]) val = val | ~((32'd1 << (8*size)) - 1);
      m_rdata = val;
    end
  endtask

  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      busy = 0; m_ready = 1'b0; m_valid = 1'b0; m_err = 1'b0; m_rdata = '0;
    end else if (m_valid) begin
      if (rsp_ready) begin
        m_valid = 1'b0; busy = 0; m_ready = 1'b1;
      end
    end else if (busy) begin
      if (cyc == acc_cyc + W + 1) begin
        model_access();
        m_valid = 1'b1;
      end
    end else if (m_ready && req_valid) begin
      p_w = req_write; p_a = req_addr; p_f3 = req_funct3; p_wd = req_wdata;
      busy = 1; acc_cyc = cyc; m_ready = 1'b0;
    end else begin
      m_ready = 1'b1;
    end
  end

  // Compare process: every cycle outside reset.
  always @(negedge clk) begin
    if (!rst) begin
      chk("req_ready", 32'(req_ready), 32'(m_ready));
      chk("rsp_valid", 32'(rsp_valid), 32'(m_valid));
      if (m_valid) begin
        chk("rsp_rdata", rsp_rdata, m_rdata);
        chk("rsp_err", 32'(rsp_err), 32'(m_err));
      end
    end
  end

  task automatic txn(input logic w, input logic [31:0] a, input logic [2:0] f3,
                     input logic [31:0] wd, input int hold, input bit keep,
                     output logic [31:0] rd, output logic e, output int lat);
    int n;
    rd = '0; e = 1'b0; lat = -1;
    @(negedge clk);
    req_write = w; req_addr = a; req_funct3 = f3; req_wdata = wd;
    req_valid = 1'b1; rsp_ready = 1'b0;
    n = 0;
    while (!req_ready && n < 50) begin @(negedge clk); n++; end
    if (!req_ready) begin
      chk("accept_timeout", 32'd0, 32'd1);
      req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1 if (!keep) req_valid = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (!rsp_valid && n < 60);
    if (!rsp_valid) begin
      chk("rsp_timeout", 32'd0, 32'd1);
      req_valid = 1'b0;
      return;
    end
    lat = n - 1;  // rising edges from accept to rsp_valid
    repeat (hold) @(negedge clk);
    rd = rsp_rdata; e = rsp_err;
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0; req_valid = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got %0d expected 0 pending", 1);
    $fatal(1);
  end

  initial begin
    logic [31:0] rd, a;
    logic        e, w;
    logic [2:0]  f3;
    int          lat, n;

    repeat (2) @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    chk("rst_rsp_err", 32'(rsp_err), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", 32'(req_ready), 32'd1);

    // Store then load a full word.
    txn(1, 32'h10, 3'b010, 32'hDEADBEEF, 0, 0, rd, e, lat);
    chk("sw_lat", lat, W + 1);
    chk("sw_rdata", rd, 32'd0);
    txn(0, 32'h10, 3'b010, 32'h0, 0, 0, rd, e, lat);
    chk("lw_lat", lat, W + 1);
    chk("lw_rdata", rd, 32'hDEADBEEF);
    chk("lw_err", 32'(e), 32'd0);

    // Byte lane store and sign/zero-extended byte loads.
    txn(1, 32'h13, 3'b000, 32'h80, 0, 0, rd, e, lat);
    txn(0, 32'h13, 3'b000, 32'h0, 0, 0, rd, e, lat);
    chk("lb", rd, 32'hFFFFFF80);
    txn(0, 32'h13, 3'b100, 32'h0, 0, 0, rd, e, lat);
    chk("lbu", rd, 32'h00000080);
    txn(0, 32'h10, 3'b010, 32'h0, 0, 0, rd, e, lat);
    chk("lw_after_sb", rd, 32'h80ADBEEF);

    // Halfword lane store and loads.
    txn(1, 32'h12, 3'b001, 32'h1234, 0, 0, rd, e, lat);
    txn(0, 32'h12, 3'b101, 32'h0, 0, 0, rd, e, lat);
    chk("lhu", rd, 32'h00001234);
    txn(0, 32'h12, 3'b001, 32'h0, 0, 0, rd, e, lat);
    chk("lh", rd, 32'h00001234);
    txn(0, 32'h10, 3'b010, 32'h0, 0, 0, rd, e, lat);
    chk("lw_after_sh", rd, 32'h1234BEEF);

    // Backpressure with req_valid kept high through RESP.
    txn(0, 32'h10, 3'b010, 32'h0, 5, 1, rd, e, lat);
    chk("bp_rdata", rd, 32'h1234BEEF);

    // Errors.
    txn(0, 32'(4 * DEPTH), 3'b010, 32'h0, 0, 0, rd, e, lat);
    chk("oob_err", 32'(e), 32'd1);
    chk("oob_rdata", rd, 32'd0);
    txn(1, 32'h10, 3'b011, 32'hFFFFFFFF, 0, 0, rd, e, lat);
    chk("bad_f3_err", 32'(e), 32'd1);
    txn(1, 32'h10, 3'b100, 32'hFFFFFFFF, 0, 0, rd, e, lat);
    chk("store_f3_100_err", 32'(e), 32'd1);
    txn(0, 32'h10, 3'b010, 32'h0, 0, 0, rd, e, lat);
    chk("lw_after_err", rd, 32'h1234BEEF);

    // Misaligned word load.
    txn(0, 32'h11, 3'b010, 32'h0, 0, 0, rd, e, lat);
`ifdef DMEM_MISALIGN_ERR_EN
    chk("mis_err", 32'(e), 32'd1);
    chk("mis_rdata", rd, 32'd0);
`else
    chk("mis_err", 32'(e), 32'd0);
    chk("mis_rdata", rd, 32'h1234BEEF);
`endif

    // Reset while a store sits in WAIT.
    @(negedge clk);
    req_write = 1'b1; req_addr = 32'h10; req_funct3 = 3'b010; req_wdata = 32'h0;
    req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 50) begin @(negedge clk); n++; end
    @(posedge clk);
    #1 req_valid = 1'b0; rst = 1'b1;
    #1 chk("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("midrst_req_ready", 32'(req_ready), 32'd0);
    @(posedge clk);
    @(negedge clk);
    chk("midrst_rsp_valid_hold", 32'(rsp_valid), 32'd0);
    rst = 1'b0;
    txn(0, 32'h10, 3'b010, 32'h0, 0, 0, rd, e, lat);
    chk("lw_after_midrst", rd, 32'h1234BEEF);

    // Fill the model window so random loads have known contents.
    for (int i = 0; i < 16; i++) txn(1, 32'(4 * i), 3'b010, $urandom, 0, 0, rd, e, lat);

    // Randomized traffic.
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(9) == 0) a = 32'h1000 + $urandom_range(255);
      else                        a = $urandom_range(63);
      if ($urandom_range(3) == 0) f3 = 3'($urandom_range(7));
      else begin
        case ($urandom_range(4))
          0: f3 = 3'd0; 1: f3 = 3'd1; 2: f3 = 3'd2; 3: f3 = 3'd4; default: f3 = 3'd5;
        endcase
      end
      w = 1'($urandom_range(1));
      txn(w, a, f3, $urandom, $urandom_range(2), ($urandom_range(3) == 0), rd, e, lat);
    end

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
